// File: rtl/sc_rr_arbiter.sv
// Round-robin arbiter: serialises N_MASTERS single-cycle-handshake masters onto one
// slave port, rotating priority after each completion, with a response watchdog.
module sc_rr_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int TIMEOUT   = 256,
    localparam int IDW      = $clog2(N_MASTERS)
) (
    input  logic                    i_clk,
    input  logic                    i_resetb,
    input  logic [N_MASTERS-1:0]    i_m_req,
    input  logic [32*N_MASTERS-1:0] i_m_addr,
    input  logic [N_MASTERS-1:0]    i_m_cmd,
    input  logic [32*N_MASTERS-1:0] i_m_wdata,
    output logic [N_MASTERS-1:0]    o_m_ack,
    output logic [31:0]             o_m_rdata,
    output logic                    o_s_req,
    output logic [31:0]             o_s_addr,
    output logic                    o_s_cmd,
    output logic [31:0]             o_s_wdata,
    input  logic                    i_s_ack,
    input  logic [31:0]             i_s_rdata,
    output logic [IDW-1:0]          o_grant_id,
    output logic                    o_busy,
    output logic                    o_timeout
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

    state_t                 state_q, state_d;
    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [IDW-1:0]         grant_q, grant_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [N_MASTERS-1:0]   ack_q, ack_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   s_req_q, s_req_d;
    logic [31:0]            s_addr_q, s_addr_d;
    logic                   s_cmd_q, s_cmd_d;
    logic [31:0]            s_wdata_q, s_wdata_d;
    logic                   busy_q, busy_d;
    logic                   timeout_q, timeout_d;

    logic [31:0] m_addr  [N_MASTERS];
    logic [31:0] m_wdata [N_MASTERS];

    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
        assign m_addr[gi]  = i_m_addr[32*gi +: 32];
        assign m_wdata[gi] = i_m_wdata[32*gi +: 32];
    end

    // First requester at or after ptr; the sum is one bit wider so it can exceed N before wrapping.
    logic           pick_vld;
    logic [IDW-1:0] pick_idx;
    logic [IDW:0]   scan;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan     = '0;
        for (int unsigned off = 0; off < N_MASTERS; off++) begin
            scan = {1'b0, ptr_q} + (IDW+1)'(off);
            if (scan >= (IDW+1)'(N_MASTERS)) begin
                scan = scan - (IDW+1)'(N_MASTERS);
            end
            if (!pick_vld && i_m_req[IDW'(scan)]) begin
                pick_vld = 1'b1;
                pick_idx = IDW'(scan);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        ack_d     = ack_q;
        rdata_d   = rdata_q;
        s_req_d   = s_req_q;
        s_addr_d  = s_addr_q;
        s_cmd_d   = s_cmd_q;
        s_wdata_d = s_wdata_q;
        busy_d    = busy_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d   = pick_idx;
                    s_addr_d  = m_addr[pick_idx];
                    s_cmd_d   = i_m_cmd[pick_idx];
                    s_wdata_d = m_wdata[pick_idx];
                    s_req_d   = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // Slave ack takes precedence over a watchdog expiry in the same cycle.
                if (i_s_ack) begin
                    rdata_d         = i_s_rdata;
                    ack_d           = '0;
                    ack_d[grant_q]  = 1'b1;
                    s_req_d         = 1'b0;
                    state_d         = ST_RESP;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    rdata_d         = TIMEOUT_DATA;
                    ack_d           = '0;
                    ack_d[grant_q]  = 1'b1;
                    timeout_d       = 1'b1;
                    s_req_d         = 1'b0;
                    state_d         = ST_RESP;
                end
            end
            ST_RESP: begin
                ack_d     = '0;
                timeout_d = 1'b0;
                ptr_d     = (grant_q == IDW'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            s_req_q   <= 1'b0;
            s_addr_q  <= '0;
            s_cmd_q   <= 1'b0;
            s_wdata_q <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            s_req_q   <= s_req_d;
            s_addr_q  <= s_addr_d;
            s_cmd_q   <= s_cmd_d;
            s_wdata_q <= s_wdata_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_m_ack    = ack_q;
    assign o_m_rdata  = rdata_q;
    assign o_s_req    = s_req_q;
    assign o_s_addr   = s_addr_q;
    assign o_s_cmd    = s_cmd_q;
    assign o_s_wdata  = s_wdata_q;
    assign o_grant_id = grant_q;
    assign o_busy     = busy_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_sc_rr_arbiter.sv
// Bench for sc_rr_arbiter: a 4-master/TIMEOUT=8 and a 3-master/TIMEOUT=0 instance,
// directed scenarios plus random traffic against a transaction-level round-robin model.
module tb_sc_rr_arbiter;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Shared master/slave stimulus; sel routes it to instance A (0) or B (1).
    logic         sel = 1'b0;
    logic [3:0]   req;
    logic [127:0] addr;
    logic [127:0] wdata;
    logic [3:0]   cmd;
    logic         s_ack;
    logic [31:0]  s_rdata;

    logic [3:0]  a_ack;
    logic [31:0] a_rdata, a_saddr, a_swdata;
    logic        a_sreq, a_scmd, a_busy, a_tmo;
    logic [1:0]  a_gid;
    logic [2:0]  b_ack;
    logic [31:0] b_rdata, b_saddr, b_swdata;
    logic        b_sreq, b_scmd, b_busy, b_tmo;
    logic [1:0]  b_gid;

    sc_rr_arbiter #(.N_MASTERS(4), .TIMEOUT(8)) u_a (
        .i_clk(clk), .i_resetb(rstn),
        .i_m_req(sel ? 4'b0 : req), .i_m_addr(addr), .i_m_cmd(cmd), .i_m_wdata(wdata),
        .o_m_ack(a_ack), .o_m_rdata(a_rdata),
        .o_s_req(a_sreq), .o_s_addr(a_saddr), .o_s_cmd(a_scmd), .o_s_wdata(a_swdata),
        .i_s_ack(s_ack & ~sel), .i_s_rdata(s_rdata),
        .o_grant_id(a_gid), .o_busy(a_busy), .o_timeout(a_tmo)
    );

    sc_rr_arbiter #(.N_MASTERS(3), .TIMEOUT(0)) u_b (
        .i_clk(clk), .i_resetb(rstn),
        .i_m_req(sel ? req[2:0] : 3'b0), .i_m_addr(addr[95:0]), .i_m_cmd(cmd[2:0]),
        .i_m_wdata(wdata[95:0]),
        .o_m_ack(b_ack), .o_m_rdata(b_rdata),
        .o_s_req(b_sreq), .o_s_addr(b_saddr), .o_s_cmd(b_scmd), .o_s_wdata(b_swdata),
        .i_s_ack(s_ack & sel), .i_s_rdata(s_rdata),
        .o_grant_id(b_gid), .o_busy(b_busy), .o_timeout(b_tmo)
    );

    logic [3:0]  ack;
    logic [31:0] rdata, saddr, swdata;
    logic        sreq, scmd, busy, tmo;
    logic [1:0]  gid;
    assign ack    = sel ? {1'b0, b_ack} : a_ack;
    assign rdata  = sel ? b_rdata  : a_rdata;
    assign saddr  = sel ? b_saddr  : a_saddr;
    assign swdata = sel ? b_swdata : a_swdata;
    assign sreq   = sel ? b_sreq   : a_sreq;
    assign scmd   = sel ? b_scmd   : a_scmd;
    assign busy   = sel ? b_busy   : a_busy;
    assign tmo    = sel ? b_tmo    : a_tmo;
    assign gid    = sel ? b_gid    : a_gid;

    // Reference model state: rotating priority pointer per instance, per-master wait count.
    int ptr_m [2];
    int waitn [4];
    int unsigned t_start;

    function automatic int nm();
        return sel ? 3 : 4;
    endfunction

    function automatic int tlim();
        return sel ? 0 : 8;
    endfunction

    function automatic int pick();
        int n = nm();
        for (int k = 0; k < n; k++) begin
            int i;
            i = (ptr_m[sel] + k) % n;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 32'({ack, gid, sreq, scmd, busy, tmo}), 32'h0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_saddr"}, saddr, 32'h0);
        chk({tag, "_swdata"}, swdata, 32'h0);
    endtask

    task automatic set_m(input int i, input logic [31:0] a, input logic c, input logic [31:0] d);
        addr[32*i +: 32]  = a;
        cmd[i]            = c;
        wdata[32*i +: 32] = d;
    endtask

    task automatic model_reset();
        ptr_m[0] = 0;
        ptr_m[1] = 0;
        for (int i = 0; i < 4; i++) waitn[i] = 0;
    endtask

    task automatic do_reset();
        rstn  = 1'b0;
        req   = '0;
        s_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    // One transaction: ack_at is the 1-based o_s_req cycle on which the slave acks, 0 = never.
    task automatic do_txn(input int ack_at, input logic [31:0] srd);
        int g, hi, w, n, t, exp_hi;
        logic to_exp;
        logic [31:0] ea, ed;
        logic ec;
        n = nm();
        t = tlim();
        g = pick();
        if (g < 0) return;
        ea = addr[32*g +: 32];
        ed = wdata[32*g +: 32];
        ec = cmd[g];
        w = 0;
        while (sreq !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("sreq_rise", sreq, 1);
        if (sreq !== 1'b1) return;
        t_start = cyc;
        chk("grant_id", gid, g);
        chk("s_addr", saddr, ea);
        chk("s_cmd", scmd, ec);
        chk("s_wdata", swdata, ed);
        chk("busy", busy, 1);
        chk("fair_wait", waitn[g] <= n - 1, 1);
        waitn[g] = 0;
        for (int i = 0; i < n; i++) if (i != g && req[i]) waitn[i]++;
        addr[32*g +: 32]  = $urandom;
        wdata[32*g +: 32] = $urandom;
        cmd[g]            = ~cmd[g];
        hi = 0;
        do begin
            hi++;
            s_ack   = (hi == ack_at);
            s_rdata = (hi == ack_at) ? srd : $urandom;
            @(negedge clk);
            s_ack = 1'b0;
        end while (sreq === 1'b1 && hi < 40);
        to_exp = !(ack_at != 0 && (t == 0 || ack_at <= t));
        exp_hi = to_exp ? t : ack_at;
        chk("sreq_cycles", hi, exp_hi);
        chk("m_ack", ack, 32'(1) << g);
        chk("m_rdata", rdata, to_exp ? 32'hDEAD_BEEF : srd);
        chk("timeout", tmo, to_exp);
        chk("s_addr_hold", saddr, ea);
        req[g]     = 1'b0;
        ptr_m[sel] = (g + 1) % n;
        @(negedge clk);
        chk("ack_pulse", ack, 0);
        chk("timeout_pulse", tmo, 0);
        chk("busy_idle", busy, 0);
    endtask

    int unsigned prev;
    int w, n, j;

    initial begin
        req = '0; addr = '0; wdata = '0; cmd = '0; s_ack = 1'b0; s_rdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_zero("reset_a");
        sel = 1'b1;
        #1;
        chk_zero("reset_b");
        sel = 1'b0;
        #1;
        rstn = 1'b1;
        @(negedge clk);

        // Single read by master 2, ack on the third o_s_req cycle.
        set_m(2, 32'h10, 1'b0, 32'h0);
        req[2] = 1'b1;
        do_txn(3, 32'hCAFE_0001);

        // Contention: all four write right after reset, immediate acks, 3-cycle spacing.
        do_reset();
        for (int i = 0; i < 4; i++) set_m(i, 32'h100 + i, 1'b1, 32'hA000_0000 + i);
        req = 4'hF;
        do_txn(1, 32'h0);
        prev = t_start;
        for (int i = 1; i < 4; i++) begin
            do_txn(1, $urandom);
            chk("spacing", t_start - prev, 3);
            prev = t_start;
        end

        // Rotation: master 1 completes, then 0 and 3 together.
        set_m(1, 32'h200, 1'b0, 32'h0);
        req[1] = 1'b1;
        do_txn(1, 32'h1111_0000);
        set_m(0, 32'h300, 1'b1, 32'h3333);
        set_m(3, 32'h400, 1'b0, 32'h4444);
        req[0] = 1'b1;
        req[3] = 1'b1;
        do_txn(2, 32'h2222_0003);
        do_txn(1, 32'h2222_0000);

        // Watchdog expiry, then ack landing on the expiry cycle.
        req[0] = 1'b1;
        do_txn(0, 32'h0);
        req[0] = 1'b1;
        do_txn(8, 32'h1234_5678);

        // Slave ack with nothing in flight.
        s_ack = 1'b1;
        @(negedge clk);
        s_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack", ack, 0);
        chk("stray_busy", busy, 0);

        // Reset while BUSY: everything clears, then regrant from pointer 0.
        set_m(1, 32'h500, 1'b0, 32'h0);
        set_m(3, 32'h600, 1'b1, 32'h6666);
        req[1] = 1'b1;
        req[3] = 1'b1;
        w = 0;
        while (sreq !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("rst_mid_sreq", sreq, 1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(negedge clk);
        chk("rst_mid_noack", ack, 0);
        rstn = 1'b1;
        model_reset();
        do_txn(2, 32'h7777_0001);
        do_txn(1, 32'h7777_0003);

        // Random traffic on A; pending masters keep their request until served.
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    set_m(i, $urandom, 1'($urandom_range(0, 1)), $urandom);
                    req[i] = 1'b1;
                end
            end
            if (req == '0) req[$urandom_range(0, 3)] = 1'b1;
            do_txn($urandom_range(0, 10), $urandom);
        end

        // Instance B: 3 masters, wrap from index 2, watchdog disabled.
        do_reset();
        sel = 1'b1;
        #1;
        chk_zero("b_idle");
        set_m(2, 32'h800, 1'b1, 32'h8888);
        req[2] = 1'b1;
        do_txn(1, 32'h0);
        set_m(0, 32'h900, 1'b0, 32'h0);
        set_m(2, 32'hA00, 1'b1, 32'hAAAA);
        req[0] = 1'b1;
        req[2] = 1'b1;
        do_txn(1, 32'hB000_0000);
        do_txn(2, 32'hB000_0002);
        set_m(1, 32'hC00, 1'b0, 32'h0);
        req[1] = 1'b1;
        do_txn(30, 32'hC0DE_0001);
        for (int it = 0; it < 20; it++) begin
            n = nm();
            for (int i = 0; i < n; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    set_m(i, $urandom, 1'($urandom_range(0, 1)), $urandom);
                    req[i] = 1'b1;
                end
            end
            if (req == '0) begin
                j = $urandom_range(0, 2);
                req[j] = 1'b1;
            end
            do_txn($urandom_range(1, 6), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sc_rr_arbiter.md
# sc_rr_arbiter

Round-robin arbiter that shares a single slave port among N_MASTERS single-cycle-handshake masters (req/addr/cmd/wdata, ack/rdata). It sits between the master devices and one slave on the crossbar. It serialises one transaction at a time, rotates priority after each completion, and guards the slave with a response watchdog.

## Interface
- N_MASTERS, 4: number of requesters, 2..16, non-power-of-two allowed.
- TIMEOUT, 256: cycles in BUSY without slave ack before forced error completion. 0 disables the watchdog.
- IDW, $clog2(N_MASTERS): grant index width (localparam).

- i_clk  in  1  clock.
- i_resetb  in  1  reset, asynchronous, active-low.
- i_m_req  in  N_MASTERS  per-master request, held until acked.
- i_m_addr  in  32*N_MASTERS  master i at [32*i+:32].
- i_m_cmd  in  N_MASTERS  1 = write, 0 = read.
- i_m_wdata  in  32*N_MASTERS  master i at [32*i+:32].
- o_m_ack  out  N_MASTERS  one-hot, single-cycle ack to the granted master.
- o_m_rdata  out  32  read data broadcast to all masters; valid only with o_m_ack.
- o_s_req / o_s_addr / o_s_cmd / o_s_wdata  out  1/32/1/32  slave-side request.
- i_s_ack  in  1  slave ack pulse.
- i_s_rdata  in  32  slave read data, valid with i_s_ack.
- o_grant_id  out  IDW  index of the current or last granted master.
- o_busy  out  1  high in BUSY and RESP.
- o_timeout  out  1  one-cycle pulse on watchdog completion.

## Operation
- The FSM has three states: IDLE, BUSY and RESP. All outputs are registered.
- **IDLE:**
  - If i_m_req is nonzero, select the first requester scanning ptr, ptr+1, …, wrapping modulo N_MASTERS.
  - Register g into o_grant_id.
  - Latch master g's addr/cmd/wdata into o_s_*, set o_s_req=1, clear the watchdog counter, and go to BUSY.
  - Request inputs are sampled only in IDLE. Addr/cmd/wdata changes after grant are ignored.
- **BUSY:**
  - o_s_req is held at 1 and the counter increments.
  - On i_s_ack: o_m_rdata<=i_s_rdata (reads and writes alike), o_m_ack[g]<=1, o_s_req<=0, go to RESP.
  - Otherwise, if TIMEOUT≠0 and the counter reaches TIMEOUT-1: o_m_rdata<=32'hDEADBEEF, o_m_ack[g]<=1, o_timeout<=1, o_s_req<=0, go to RESP.
  - If i_s_ack and the timeout coincide in the same cycle, i_s_ack wins and o_timeout stays 0.
- **RESP:**
  - o_m_ack<=0 and o_timeout<=0.
  - ptr<=(g==N_MASTERS-1)?0:g+1.
  - Go to IDLE.
  - This cycle absorbs the master's req deassertion, so the same request is never granted twice.
- i_s_ack outside BUSY is ignored.
- o_s_addr/cmd/wdata keep their last value after completion. Only o_s_req qualifies them.
- Fairness: a continuously requesting master waits at most N_MASTERS-1 transactions.
- Reset (at any time, including mid-transaction): state IDLE, ptr 0. All outputs go to 0: o_m_ack, o_m_rdata, o_s_*, o_grant_id, o_busy, o_timeout. A pending transaction is abandoned with no ack delivered.

## Timing
- Cycle 0: master req sampled in IDLE.
- Cycle 1: o_s_req high, o_busy high.
- Slave acks in cycle k ≥ 1, so o_m_ack is high in cycle k+1 and the FSM is back in IDLE in cycle k+2.
- Minimum turnaround is 3 cycles per transaction; peak throughput is one transaction per 3 cycles.
- Timeout: o_s_req is high for exactly TIMEOUT cycles. The forced ack is high in the following cycle.
- Masters must drop req, or present a new request, no later than the cycle after o_m_ack. A req still high in IDLE is treated as a new transaction.

## Test plan
- **Single read:** master 2 reads addr 0x10, slave acks 2 cycles after o_s_req with 0xCAFE0001 -> o_s_addr=0x10, o_s_cmd=0, o_m_ack=4'b0100 for one cycle, o_m_rdata=0xCAFE0001, o_grant_id=2.
- **Contention:** all 4 masters write simultaneously after reset, slave acks immediately -> grant order 0,1,2,3, each o_s_wdata matches its master, transactions spaced 3 cycles apart.
- **Rotation:** after master 1 completes, masters 0 and 3 request together -> 3 granted first, then 0. With N_MASTERS=3, completion on index 2 wraps ptr to 0.
- **Timeout:** TIMEOUT=8, slave never acks -> o_s_req high 8 cycles, then o_m_ack with 0xDEADBEEF and o_timeout pulse. With TIMEOUT=0 the arbiter waits indefinitely.
- **Collision:** i_s_ack lands on the timeout cycle -> slave data returned, o_timeout=0.
- **Reset mid-BUSY:** assert i_resetb=0 while o_s_req=1 -> all outputs 0 immediately, no o_m_ack. After release, the still-requesting master is regranted from ptr=0.
